hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the 5-stage pipelined CPU, sitting beside the IF/ID register and driving PC enable, IF/ID enable and ID/EX bubble insertion. Unlike the previous combinational stall check, it keeps its own clocked shift-register scoreboard of in-flight destinations, so it needs only the decode-stage instruction. It supports a forwarding mode that stalls only on load-use and emits per-operand forwarding selects. It also flushes on taken branches and keeps a saturating stall-cycle counter.

## Interface
- DEPTH, 3: in-flight stages tracked after decode (entry 0 = EX, 1 = MEM, 2 = WB); legal 1..7.
- FORWARD_EN, 1: 1 = forwarding mode; 0 = stall-on-any-match mode.
- CNT_W, 16: stall counter width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_id  in  32  instruction currently in ID.
- flush  in  1  taken branch/jump resolved this cycle; squash ID instruction.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register write enable.
- idex_nop  out  1  load bubble into ID/EX instead of instr_id.
- fwd_a  out  3  rs operand source: 0 = register file, k = scoreboard entry k-1.
- fwd_b  out  3  rt operand source, same encoding.
- stall_cnt  out  CNT_W  hazard-stall cycles since reset, saturating.

## Operation
- Decode (combinational, on instr_id[31:26]):
  - Destinations: R-type 0x00 → rd = [15:11]; addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A, lw 0x23 → rt = [20:16].
  - No destination: sw 0x2B, beq 0x04, bne 0x05, j 0x02, NOP 0x3F, any other opcode.
  - Sources: R-type, sw, beq, bne → rs and rt; addi/andi/ori/slti/lw → rs only; j, NOP, unknown → none.
  - is_load = (opcode == 0x23).
- Register 0 is never a hazard: a source or destination equal to 0 is treated as invalid.
- Scoreboard: DEPTH entries of {valid, dest[4:0], is_load}. On each clock edge, entry k moves to entry k+1, and entry DEPTH-1 is discarded.
- Entry 0 loads the decode of instr_id when idex_nop = 0, and {0,0,0} when idex_nop = 1.
- match(src, k) = src valid && entry k valid && entry k dest == src.
- FORWARD_EN = 0:
  - hazard = any match over any entry, for rs or rt.
  - fwd_a = fwd_b = 0 always.
- FORWARD_EN = 1:
  - hazard = match(rs,0) or match(rt,0) with entry 0 is_load (load-use).
  - Otherwise fwd_x = 1 + lowest k with match(x, k) (the youngest producer wins), else 0.
  - When hazard = 1, fwd_a = fwd_b = 0.
- Outputs:
  - flush = 1: pc_en = 1, ifid_en = 1, idex_nop = 1, fwd = 0. Flush dominates hazard, and hazard is not counted.
  - flush = 0, hazard = 1: pc_en = 0, ifid_en = 0, idex_nop = 1.
  - flush = 0, hazard = 0: pc_en = 1, ifid_en = 1, idex_nop = 0.
- stall_cnt increments on each clock edge where hazard && !flush, and holds at 2^CNT_W - 1.

## Timing
- pc_en, ifid_en, idex_nop, fwd_a and fwd_b are combinational from instr_id, flush and the scoreboard registers, with no internal delay. They settle within the same cycle.
- The scoreboard and stall_cnt update on the rising edge of clk.
- Reset (rst_n = 0, asynchronous): all entries invalid, stall_cnt = 0. As a result pc_en = 1, ifid_en = 1, idex_nop = 0, fwd_a = fwd_b = 0, unless instr_id/flush force otherwise.
- Reset asserted mid-stall clears the stall immediately, without waiting for a clock edge.
- Stall length:
  - Load-use in FORWARD_EN = 1: exactly 1 cycle.
  - FORWARD_EN = 0: up to DEPTH cycles, ending the cycle after the producer leaves entry DEPTH-1.
- With a held instr_id, a stall always terminates, because bubbles are shifted in.

## Test plan
- Reset, then instr_id = 0xFC000000 (NOP) → pc_en = 1, ifid_en = 1, idex_nop = 0, fwd_a = 0, stall_cnt = 0.
- FORWARD_EN = 1: lw $1,0($2) (0x8C410000), then add $4,$1,$5 (0x00252020) → exactly 1 cycle with pc_en = 0, idex_nop = 1. The next cycle gives fwd_a = 2, fwd_b = 0, and stall_cnt = 1.
- FORWARD_EN = 1: add $3,$1,$2 (0x00221820), then add $4,$3,$3 (0x00632020) → no stall, fwd_a = fwd_b = 1.
  - With an intervening NOP: fwd = 2.
  - With two NOPs: fwd = 3.
- FORWARD_EN = 0, DEPTH = 3: 0x00221820, then 0x00632020 → 3 stall cycles (idex_nop = 1), then release, stall_cnt = 3.
- addi $0,$0,1 (0x20000001), then add $4,$0,$0 → no stall, fwd = 0. flush = 1 during a pending load-use → pc_en = 1, idex_nop = 1, and stall_cnt unchanged.
- CNT_W = 2 with 5 consecutive hazard cycles → stall_cnt saturates at 3. rst_n pulsed low mid-stall → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard unit tracking in-flight destinations in a shift-register scoreboard,
// with load-use/any-match stalling, forwarding selects, flush handling and a saturating stall counter.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_id,
  input  logic             flush,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_nop,
  output logic [2:0]       fwd_a,
  output logic [2:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [5:0] op;
  logic [4:0] rs, rt, dst;
  logic i_op, br_op, rs_v, rt_v, dst_v, ld, hazard;
  logic [2:0] fa, fb;
  logic sb_v [DEPTH];
  logic [4:0] sb_d [DEPTH];
  logic sb_l [DEPTH];
  logic unused_bits;
  assign unused_bits = ^instr_id[10:0];
  assign op = instr_id[31:26];
  assign rs = instr_id[25:21];
  assign rt = instr_id[20:16];
  assign i_op = op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0A || op == 6'h23;
  assign br_op = op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05;
  assign ld = op == 6'h23;
  assign dst = op == 6'h00 ? instr_id[15:11] : rt;
  assign dst_v = (op == 6'h00 || i_op) && dst != 5'd0;
  assign rs_v = (br_op || i_op) && rs != 5'd0;
  assign rt_v = br_op && rt != 5'd0;
  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fa = '0;
    fb = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs_v && sb_v[k] && sb_d[k] == rs) fa = 3'(k + 1);
      if (rt_v && sb_v[k] && sb_d[k] == rt) fb = 3'(k + 1);
    end
    hazard = FORWARD_EN ? sb_l[0] && (fa == 3'd1 || fb == 3'd1) : fa != 3'd0 || fb != 3'd0;
  end
  assign pc_en = flush || !hazard;
  assign ifid_en = pc_en;
  assign idex_nop = flush || hazard;
  assign fwd_a = FORWARD_EN && !idex_nop ? fa : 3'd0;
  assign fwd_b = FORWARD_EN && !idex_nop ? fb : 3'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_v[k] <= 1'b0;
        sb_d[k] <= '0;
        sb_l[k] <= 1'b0;
      end
      stall_cnt <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb_v[k] <= sb_v[k-1];
        sb_d[k] <= sb_d[k-1];
        sb_l[k] <= sb_l[k-1];
      end
      sb_v[0] <= !idex_nop && dst_v;
      sb_d[0] <= idex_nop ? 5'd0 : dst;
      sb_l[0] <= !idex_nop && ld;
      if (hazard && !flush && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three hazard_scoreboard configurations driven in parallel (forwarding depth 3,
// stall-on-match depth 3, stall-on-match depth 7 with a 2-bit counter), checked against an in-flight queue model.
module tb_hazard_scoreboard;
  localparam logic [31:0] NOP = 32'hFC000000, LW = 32'h8C410000, ADD_L = 32'h00252020;
  localparam logic [31:0] ADD3 = 32'h00221820, ADD4 = 32'h00632020, ADDI0 = 32'h20000001, ADD00 = 32'h00002020;
  logic clk, rst_n, flush;
  logic [31:0] instr;
  logic pe [3], ie [3], nopo [3];
  logic [2:0] fa [3], fb [3];
  logic [15:0] c0, c1, cnt [3];
  logic [1:0] c2;
  int dep [3] = '{3, 3, 7};
  bit fe [3] = '{1'b1, 1'b0, 1'b0};
  int cw [3] = '{16, 16, 2};
  int hist [3][$];
  bit e_pc [3], e_nop [3], e_haz [3];
  int e_fa [3], e_fb [3], e_cnt [3];
  int p_entry;
  int n_tests = 0, n_fail = 0;

  hazard_scoreboard #(.DEPTH(3), .FORWARD_EN(1'b1), .CNT_W(16)) d0 (.clk(clk), .rst_n(rst_n), .instr_id(instr), .flush(flush),
    .pc_en(pe[0]), .ifid_en(ie[0]), .idex_nop(nopo[0]), .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_cnt(c0));
  hazard_scoreboard #(.DEPTH(3), .FORWARD_EN(1'b0), .CNT_W(16)) d1 (.clk(clk), .rst_n(rst_n), .instr_id(instr), .flush(flush),
    .pc_en(pe[1]), .ifid_en(ie[1]), .idex_nop(nopo[1]), .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_cnt(c1));
  hazard_scoreboard #(.DEPTH(7), .FORWARD_EN(1'b0), .CNT_W(2)) d2 (.clk(clk), .rst_n(rst_n), .instr_id(instr), .flush(flush),
    .pc_en(pe[2]), .ifid_en(ie[2]), .idex_nop(nopo[2]), .fwd_a(fa[2]), .fwd_b(fb[2]), .stall_cnt(c2));
  assign cnt[0] = c0;
  assign cnt[1] = c1;
  assign cnt[2] = {14'b0, c2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic decode(input logic [31:0] i, output int dst, output bit ld, output int rs, output int rt);
    int op;
    op = int'(i[31:26]);
    rs = int'(i[25:21]);
    rt = int'(i[20:16]);
    dst = 0;
    ld = op == 35;
    case (op)
      0: dst = int'(i[15:11]);
      8, 12, 13, 10, 35: begin dst = int'(i[20:16]); rt = 0; end
      43, 4, 5: ;
      default: begin rs = 0; rt = 0; end
    endcase
  endtask

  // Expected outputs from the in-flight list: index 0 is the instruction now in EX.
  task automatic predict();
    int dst, rs, rt, r, a, b;
    bit ld, hz;
    decode(instr, dst, ld, rs, rt);
    p_entry = dst == 0 ? 0 : dst + (ld ? 32 : 0);
    for (int c = 0; c < 3; c++) begin
      a = 0;
      b = 0;
      hz = 0;
      for (int k = 0; k < dep[c]; k++) begin
        r = hist[c][k] % 32;
        if (r != 0 && r == rs && a == 0) a = k + 1;
        if (r != 0 && r == rt && b == 0) b = k + 1;
        if (!fe[c] && r != 0 && (r == rs || r == rt)) hz = 1;
      end
      if (fe[c]) hz = hist[c][0] >= 32 && (a == 1 || b == 1);
      if (!fe[c] || hz || flush) begin a = 0; b = 0; end
      e_pc[c] = flush || !hz;
      e_nop[c] = flush || hz;
      e_haz[c] = hz && !flush;
      e_fa[c] = a;
      e_fb[c] = b;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      hist[c] = {};
      repeat (dep[c]) hist[c].push_back(0);
      e_cnt[c] = 0;
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic f);
    instr = i;
    flush = f;
    predict();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      hist[c].push_front(e_nop[c] ? 0 : p_entry);
      void'(hist[c].pop_back());
      if (e_haz[c] && e_cnt[c] != (1 << cw[c]) - 1) e_cnt[c]++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr = NOP;
    flush = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(NOP, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if ({pe[c], ie[c], nopo[c], fa[c], fb[c]} !== 9'b110_000_000 || cnt[c] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: pc_en=%b ifid_en=%b idex_nop=%b fwd_a=%0d fwd_b=%0d cnt=%0d, required 1 1 0 0 0 0", c, pe[c], ie[c], nopo[c], fa[c], fb[c], cnt[c]);
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(LW, 1'b0);
    tick();
    drive(ADD_L, 1'b0);
    n_tests++;
    if (pe[0] !== 1'b0 || nopo[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_stall: pc_en=%b idex_nop=%b, required 0 1", pe[0], nopo[0]);
    end
    tick();
    drive(ADD_L, 1'b0);
    n_tests++;
    if (pe[0] !== 1'b1 || nopo[0] !== 1'b0 || fa[0] !== 3'd2 || fb[0] !== 3'd0 || cnt[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL load_use_release: pc_en=%b idex_nop=%b fwd_a=%0d fwd_b=%0d cnt=%0d, required 1 0 2 0 1", pe[0], nopo[0], fa[0], fb[0], cnt[0]);
    end
  endtask

  task automatic test_fwd_distance();
    for (int n = 0; n < 3; n++) begin
      do_reset();
      drive(ADD3, 1'b0);
      tick();
      repeat (n) begin drive(NOP, 1'b0); tick(); end
      drive(ADD4, 1'b0);
      n_tests++;
      if (pe[0] !== 1'b1 || fa[0] !== 3'(n + 1) || fb[0] !== 3'(n + 1)) begin
        n_fail++;
        $display("FAIL fwd_distance gap=%0d: pc_en=%b fwd_a=%0d fwd_b=%0d, required 1 %0d %0d", n, pe[0], fa[0], fb[0], n + 1, n + 1);
      end
    end
  endtask

  task automatic test_stall_any();
    int s1, s2;
    s1 = 0;
    s2 = 0;
    do_reset();
    drive(ADD3, 1'b0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(ADD4, 1'b0);
      if (nopo[1]) s1++;
      if (nopo[2]) s2++;
      tick();
    end
    drive(ADD4, 1'b0);
    n_tests++;
    if (s1 != 3 || cnt[1] !== 16'd3 || pe[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_depth3: stalls=%0d cnt=%0d pc_en=%b, required 3 3 1", s1, cnt[1], pe[1]);
    end
    n_tests++;
    if (s2 != 7 || cnt[2] !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_depth7_sat: stalls=%0d cnt=%0d, required 7 3", s2, cnt[2]);
    end
  endtask

  task automatic test_reg0();
    do_reset();
    drive(ADDI0, 1'b0);
    tick();
    drive(ADD00, 1'b0);
    n_tests++;
    if (pe[0] !== 1'b1 || pe[1] !== 1'b1 || fa[0] !== 3'd0 || fb[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL reg0: pc_en=%b/%b fwd_a=%0d fwd_b=%0d, required 1/1 0 0", pe[0], pe[1], fa[0], fb[0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(LW, 1'b0);
    tick();
    drive(ADD_L, 1'b1);
    n_tests++;
    if (pe[0] !== 1'b1 || ie[0] !== 1'b1 || nopo[0] !== 1'b1 || fa[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_outs: pc_en=%b ifid_en=%b idex_nop=%b fwd_a=%0d, required 1 1 1 0", pe[0], ie[0], nopo[0], fa[0]);
    end
    tick();
    drive(NOP, 1'b0);
    n_tests++;
    if (cnt[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL flush_cnt: cnt=%0d, required 0", cnt[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(ADD3, 1'b0);
    tick();
    drive(ADD4, 1'b0);
    tick();
    tick();
    n_tests++;
    if (nopo[2] !== 1'b1 || cnt[2] !== 16'd2) begin
      n_fail++;
      $display("FAIL pre_reset_stall: idex_nop=%b cnt=%0d, required 1 2", nopo[2], cnt[2]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (pe[2] !== 1'b1 || nopo[2] !== 1'b0 || cnt[2] !== 16'd0 || pe[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: pc_en=%b idex_nop=%b cnt=%0d pc_en1=%b, required 1 0 0 1", pe[2], nopo[2], cnt[2], pe[1]);
    end
    do_reset();
  endtask

  task automatic test_random();
    int ops [12] = '{0, 8, 12, 13, 10, 35, 43, 4, 5, 2, 63, 17};
    logic [8:0] ex;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive({6'(ops[$urandom_range(0, 11)]), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 11'h020}, $urandom_range(0, 9) == 0);
      for (int c = 0; c < 3; c++) begin
        ex = {e_pc[c], e_pc[c], e_nop[c], 3'(e_fa[c]), 3'(e_fb[c])};
        n_tests++;
        if ({pe[c], ie[c], nopo[c], fa[c], fb[c]} !== ex) begin
          n_fail++;
          $display("FAIL random_outs dut%0d cyc%0d instr=%h flush=%b: got %b, required %b", c, i, instr, flush, {pe[c], ie[c], nopo[c], fa[c], fb[c]}, ex);
        end
        n_tests++;
        if (cnt[c] !== 16'(e_cnt[c])) begin
          n_fail++;
          $display("FAIL random_cnt dut%0d cyc%0d: got %0d, required %0d", c, i, cnt[c], e_cnt[c]);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr = NOP;
    flush = 1'b0;
    test_reset();
    test_load_use();
    test_fwd_distance();
    test_stall_any();
    test_reg0();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
